// File: rtl/ifetch_prefetch_pkg.sv
// Shared definitions for the prefetching fetch stage: memory base, instruction width,
// realigner decision record and the compressed-opcode length check.
package ifetch_prefetch_pkg;

  localparam logic [63:0] PMEM_START = 64'h0000_0000_8000_0000;
  localparam int          INST_W     = 32;

  // One realigner decision: what decode sees and whether the FIFO head retires.
  typedef struct packed {
    logic              valid;
    logic              rvc;
    logic              pop;
    logic [INST_W-1:0] inst;
  } align_t;

  // Compressed instructions are those whose low two opcode bits are not 2'b11.
  function automatic logic is_rvc(input logic [1:0] op);
    return op != 2'b11;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous DEPTH x 32 word FIFO with push, pop, synchronous clear, occupancy count
// and combinational peek of the head and the entry behind it.
module ifetch_fifo
  import ifetch_prefetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic [INST_W-1:0] push_data,
  input  logic              pop,
  output logic [CW-1:0]     count,
  output logic [INST_W-1:0] head,
  output logic [INST_W-1:0] head1
);

  logic [INST_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     rd_next;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && !clear;
  assign do_pop  = pop && !clear && (count != '0);
  assign rd_next = rd_ptr + 1'b1;
  assign head    = mem[rd_ptr];
  assign head1   = mem[rd_next];

  // NOTE: the storage array is deliberately not reset; only pointers and count are, and
  // an entry is never read before a push has written it.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // the pre-edge value of its neighbours regardless of block evaluation order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_next;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The credit rule upstream guarantees a free slot for every accepted response.
  overflow_chk: assert property (@(posedge clock) disable iff (reset)
    !(do_push && (count == CW'(DEPTH))));

endmodule

// File: rtl/ifetch_prefetch.sv
// Prefetching fetch stage: credit-limited word requests, in-order response buffering,
// redirect flush with stale-response dropping, and 16/32-bit realignment for decode.
// Compressed (RVC) support is built only when IFETCH_RVC_EN is defined.
module ifetch_prefetch
  import ifetch_prefetch_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(PMEM_START),
  parameter int              DEPTH    = 4
) (
  input  logic              clock,
  input  logic              reset,
  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic [XLEN-1:0]   req_addr_o,
  input  logic              rsp_valid_i,
  input  logic [INST_W-1:0] rsp_data_i,
  input  logic              redirect_i,
  input  logic [XLEN-1:0]   redirect_pc_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [XLEN-1:0]   out_pc_o,
  output logic [INST_W-1:0] out_inst_o,
  output logic              out_rvc_o
);

  localparam int              CW        = $clog2(DEPTH + 1);
  localparam logic [CW:0]     CREDITS   = (CW + 1)'(DEPTH);
  localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);
`ifdef IFETCH_RVC_EN
  localparam logic [XLEN-1:0] PC_MASK   = ~XLEN'(1);
`else
  localparam logic [XLEN-1:0] PC_MASK   = ~XLEN'(3);
`endif

  logic [XLEN-1:0]   fetch_addr;
  logic [XLEN-1:0]   out_pc;
  logic [XLEN-1:0]   pc_step;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     drop_cnt;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       credit_used;
  logic [INST_W-1:0] w0;
  logic [INST_W-1:0] w1;
  logic              req_fire;
  logic              push;
  logic              pop;
  logic              out_fire;
  align_t            al;

  // Requests in flight plus buffered words never exceed the FIFO size.
  assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
  assign req_valid_o = !reset && !redirect_i && (credit_used < CREDITS);
  assign req_fire    = req_valid_o && req_ready_i;
  assign req_addr_o  = fetch_addr;

  // A response in a redirect cycle belongs to the old stream and is discarded.
  assign push     = rsp_valid_i && (drop_cnt == '0) && !redirect_i;
  assign out_fire = al.valid && out_ready_i && !redirect_i;
  assign pop      = out_fire && al.pop;

  ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (redirect_i),
    .push      (push),
    .push_data (rsp_data_i),
    .pop       (pop),
    .count     (fifo_count),
    .head      (w0),
    .head1     (w1)
  );

  always_comb begin
    // NOTE: the whole record gets a default before any branch, so no path can leave a
    // field unassigned and infer a latch.
    al = '0;
`ifdef IFETCH_RVC_EN
    if (!out_pc[1]) begin
      al.valid = fifo_count != '0;
      if (is_rvc(w0[1:0])) begin
        al.rvc  = 1'b1;
        al.inst = INST_W'(w0[15:0]);
      end else begin
        al.pop  = 1'b1;
        al.inst = w0;
      end
    end else if (is_rvc(w0[17:16])) begin
      al.valid = fifo_count != '0;
      al.rvc   = 1'b1;
      al.pop   = 1'b1;
      al.inst  = INST_W'(w0[31:16]);
    end else begin
      // Straddling 32-bit instruction: upper half of head, lower half of the next word.
      al.valid = fifo_count >= CW'(2);
      al.pop   = 1'b1;
      al.inst  = {w1[15:0], w0[31:16]};
    end
`else
    al.valid = fifo_count != '0;
    al.pop   = 1'b1;
    al.inst  = w0;
`endif
  end

`ifndef IFETCH_RVC_EN
  logic unused_w1;
  assign unused_w1 = ^w1;
`endif

  assign pc_step     = al.rvc ? XLEN'(2) : XLEN'(4);
  assign out_valid_o = al.valid;
  assign out_inst_o  = al.inst;
  assign out_rvc_o   = al.rvc;
  assign out_pc_o    = out_pc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_addr  <= RESET_PC & WORD_MASK;
      out_pc      <= RESET_PC & PC_MASK;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      if (redirect_i) begin
        fetch_addr <= redirect_pc_i & WORD_MASK;
        out_pc     <= redirect_pc_i & PC_MASK;
        drop_cnt   <= outstanding - CW'(rsp_valid_i);
      end else begin
        if (req_fire) fetch_addr <= fetch_addr + XLEN'(4);
        if (out_fire) out_pc <= out_pc + pc_step;
        if (rsp_valid_i && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
      end
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_valid_i);
    end
  end

  // Memory returns exactly one response per accepted request.
  rsp_underflow_chk: assert property (@(posedge clock) disable iff (reset)
    rsp_valid_i |-> (outstanding != '0));

endmodule
